// File: rtl/seg_pkg.sv
// Shared types and frame geometry for the 7-segment serial display path.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH
    } seg_state_e;

    localparam int SEG_DIGITS  = 8;
    localparam int SEG_FRAME_W = SEG_DIGITS * 8;

endpackage

// File: rtl/seg_half_tick.sv
// Prescaler producing a one-cycle tick every HALF clk cycles while enabled.
module seg_half_tick #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = $clog2(HALF + 1);
    localparam logic [CW-1:0] TERM = CW'(HALF - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter is held at zero while disabled so every SHIFT entry starts a full half-period.
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            cnt_d  = '0;
            tick_o = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_p2s_tx.sv
// Captures a full display frame and shifts it MSB-first into an external 74HC595 chain,
// then pulses the storage latch. All pin outputs come straight from flops.
module seg_p2s_tx
    import seg_pkg::*;
#(
    parameter int DATA_W   = SEG_FRAME_W,
    parameter int HALF     = 2,
    parameter int LATCH_CY = 2,
    parameter bit INV      = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] par_data,
    output logic              busy,
    output logic              done,
    output logic              s_clk,
    output logic              s_dat,
    output logic              s_latch,
    output logic              s_clr_n
);

    localparam int BCW = $clog2(DATA_W);
    localparam int LCW = $clog2(LATCH_CY + 1);

    seg_state_e        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [LCW-1:0]    lat_cnt_q, lat_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              s_clk_q, s_clk_d;
    logic              s_dat_q, s_dat_d;
    logic              s_latch_q, s_latch_d;
    logic              s_clr_n_q, s_clr_n_d;
    logic              tick;

    seg_half_tick #(
        .HALF(HALF)
    ) u_half_tick (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == SHIFT),
        .tick_o(tick)
    );

    // s_clk_q doubles as the bit phase: low half first, then high half.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        lat_cnt_d = lat_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        s_clk_d   = s_clk_q;
        s_dat_d   = s_dat_q;
        s_latch_d = s_latch_q;
        s_clr_n_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                shreg_d   = par_data;
                bit_cnt_d = BCW'(DATA_W - 1);
                s_dat_d   = par_data[DATA_W-1] ^ INV;
                s_clk_d   = 1'b0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    if (!s_clk_q) begin
                        s_clk_d = 1'b1;
                    end else begin
                        s_clk_d = 1'b0;
                        if (bit_cnt_q == '0) begin
                            state_d   = LATCH;
                            s_latch_d = 1'b1;
                            lat_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q - BCW'(1);
                            shreg_d   = shreg_q << 1;
                            s_dat_d   = shreg_q[DATA_W-2] ^ INV;
                        end
                    end
                end
            end
            LATCH: begin
                // LATCH_CY strobe cycles, then one done cycle before returning to IDLE.
                lat_cnt_d = lat_cnt_q + LCW'(1);
                if (lat_cnt_q == LCW'(LATCH_CY - 1)) begin
                    s_latch_d = 1'b0;
                    done_d    = 1'b1;
                end else if (lat_cnt_q == LCW'(LATCH_CY)) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    s_dat_d   = INV;
                    lat_cnt_d = lat_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            lat_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            s_clk_q   <= 1'b0;
            s_dat_q   <= INV;
            s_latch_q <= 1'b0;
            s_clr_n_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            lat_cnt_q <= lat_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            s_clk_q   <= s_clk_d;
            s_dat_q   <= s_dat_d;
            s_latch_q <= s_latch_d;
            s_clr_n_q <= s_clr_n_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign s_clk   = s_clk_q;
    assign s_dat   = s_dat_q;
    assign s_latch = s_latch_q;
    assign s_clr_n = s_clr_n_q;

endmodule

// File: tb/tb_seg_p2s_tx.sv
// Scoreboard bench for seg_p2s_tx: default, inverted-data and fast (HALF=1, LATCH_CY=1) instances.
module tb_seg_p2s_tx;

    logic        clk;
    logic        rst;
    logic [2:0]  start_a;
    logic [63:0] pd_a [3];
    logic [2:0]  busy_a, done_a, s_clk_a, s_dat_a, s_latch_a, s_clr_n_a;
    logic [5:0]  outs_a [3];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int H = (gi == 2) ? 1 : 2;
        localparam int L = (gi == 2) ? 1 : 2;
        localparam bit I = (gi == 1);

        logic [63:0] exp_q [$];
        int overlap;

        seg_p2s_tx #(
            .DATA_W  (64),
            .HALF    (H),
            .LATCH_CY(L),
            .INV     (I)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start_a[gi]),
            .par_data(pd_a[gi]),
            .busy    (busy_a[gi]),
            .done    (done_a[gi]),
            .s_clk   (s_clk_a[gi]),
            .s_dat   (s_dat_a[gi]),
            .s_latch (s_latch_a[gi]),
            .s_clr_n (s_clr_n_a[gi])
        );

        assign outs_a[gi] = {busy_a[gi], done_a[gi], s_clk_a[gi], s_dat_a[gi], s_latch_a[gi], s_clr_n_a[gi]};

        // Capture s_dat on every s_clk rise; compare against the scoreboard at done.
        initial begin : mon
            logic [63:0] cap;
            logic [63:0] exp_v;
            logic        prev;
            int          rises;
            int          frames;
            cap = '0; prev = 1'b0; rises = 0; frames = 0; overlap = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    cap = '0; prev = 1'b0; rises = 0;
                end else begin
                    if (s_clk_a[gi] && !prev) begin
                        cap = {cap[62:0], s_dat_a[gi]};
                        rises++;
                    end
                    prev = s_clk_a[gi];
                    if (s_clk_a[gi] && s_latch_a[gi]) overlap++;
                    if (done_a[gi]) begin
                        if (exp_q.size() == 0) begin
                            check_eq("done_without_frame", 64'(exp_q.size()), 64'd1);
                        end else begin
                            exp_v = exp_q.pop_front();
                            check_eq("frame_bits", cap, exp_v);
                            check_eq("rise_count", 64'(rises), 64'd64);
                            $display("inst %0d frame %0d: sent %016h expected %016h rises %0d",
                                     gi, frames, cap, exp_v, rises);
                            frames++;
                        end
                        cap = '0; rises = 0;
                    end
                end
            end
        end
    end

    task automatic push_exp(input int k, input logic [63:0] v);
        case (k)
            0:       g_dut[0].exp_q.push_back(v);
            1:       g_dut[1].exp_q.push_back(v);
            default: g_dut[2].exp_q.push_back(v);
        endcase
    endtask

    // Asserts rst at the current time; outputs must react without a clock edge.
    task automatic apply_reset();
        logic [5:0] e;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            e = 6'b000000;
            e[2] = (k == 1);
            check_eq("rst_outs", outs_a[k], e);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("clr_n_held", s_clr_n_a, 3'b000);
        @(posedge clk);
        #1;
        check_eq("clr_n_rise", s_clr_n_a, 3'b111);
    endtask

    // Drives one frame on instance k and checks timing relative to the start cycle (n=0).
    task automatic run_frame(input int k, input logic [63:0] data, input bit glitch, input bit hold_start);
        int h, l, lat;
        int busy_first, busy_last, lat_first, lat_last, done_at, done_cnt;
        h = (k == 2) ? 1 : 2;
        l = (k == 2) ? 1 : 2;
        lat = 1 + 64 * 2 * h + l + 1;
        busy_first = -1; busy_last = -1; lat_first = -1; lat_last = -1;
        done_at = -1; done_cnt = 0;
        @(posedge clk);
        #1;
        start_a[k] = 1'b1;
        pd_a[k]    = data;
        push_exp(k, (k == 1) ? ~data : data);
        for (int n = 0; n <= lat + 3; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
                if (n == 1 && !hold_start) start_a[k] = 1'b0;
                if (n == 2) pd_a[k] = ~data;
                if (glitch && n == 174) begin
                    start_a[k] = 1'b1;
                    pd_a[k]    = {$urandom, $urandom};
                end
                if (glitch && n == 175) start_a[k] = 1'b0;
            end
            @(negedge clk);
            if (busy_a[k]) begin
                if (busy_first < 0) busy_first = n;
                busy_last = n;
            end
            if (s_latch_a[k]) begin
                if (lat_first < 0) lat_first = n;
                lat_last = n;
            end
            if (done_a[k]) begin
                done_cnt++;
                done_at = n;
            end
            if (done_at >= 0 && (hold_start || n > done_at)) break;
        end
        check_eq("busy_rise", busy_first, 1);
        check_eq("busy_fall", busy_last, lat);
        check_eq("latch_first", lat_first, lat - l);
        check_eq("latch_last", lat_last, lat - 1);
        check_eq("done_cycle", done_at, lat);
        check_eq("done_count", done_cnt, 1);
    endtask

    initial begin
        int done_cnt;
        rst = 1'b1;
        start_a = '0;
        for (int k = 0; k < 3; k++) pd_a[k] = '0;
        #2;
        apply_reset();

        run_frame(0, 64'hF0F0_1234_8000_0001, 1'b0, 1'b0);
        run_frame(0, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
        run_frame(0, 64'hA5A5_5A5A_FFFF_0000, 1'b0, 1'b1);
        run_frame(0, 64'h8000_0000_0000_0001, 1'b0, 1'b0);

        run_frame(1, 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("inv_idle_dat", s_dat_a[1], 1'b1);

        run_frame(2, 64'hDEAD_BEEF_0F1E_2D3C, 1'b0, 1'b0);
        run_frame(2, {$urandom, $urandom}, 1'b0, 1'b0);

        // Abort a frame in the high phase of bit 30 (n=136 after start).
        @(posedge clk);
        #1;
        start_a[0] = 1'b1;
        pd_a[0]    = '1;
        @(posedge clk);
        #1;
        start_a[0] = 1'b0;
        repeat (135) @(posedge clk);
        #1;
        check_eq("pre_rst_busy_clk_dat", {busy_a[0], s_clk_a[0], s_dat_a[0]}, 3'b111);
        apply_reset();
        done_cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (done_a[0]) done_cnt++;
        end
        check_eq("no_done_after_rst", done_cnt, 0);
        check_eq("idle_busy", busy_a, 3'b000);

        check_eq("sb_drain0", g_dut[0].exp_q.size(), 0);
        check_eq("sb_drain1", g_dut[1].exp_q.size(), 0);
        check_eq("sb_drain2", g_dut[2].exp_q.size(), 0);
        check_eq("clk_latch_overlap0", g_dut[0].overlap, 0);
        check_eq("clk_latch_overlap1", g_dut[1].overlap, 0);
        check_eq("clk_latch_overlap2", g_dut[2].overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
